pipe_ctrl_unit: RTL

//  Decode/issue control for the pipelined MIPS core. Decodes the ID-stage opcode/func

---
 rtl/pipe_ctrl_unit.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - MIPS ID-stage decode/issue control with load-use, flush, SYSCALL drain and MULT/DIV interlocks.
// Optional HI/LO multiply/divide support is built when PIPE_CTRL_MULDIV_EN is defined.
module pipe_ctrl_unit #(
  parameter int ALUOP_W      = 3,
  parameter int DRAIN_CYCLES = 3,
  parameter int MULDIV_LAT   = 8
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               id_valid,
  input  logic [5:0]         id_opcode,
  input  logic [5:0]         id_func,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic [4:0]         id_rd,
  input  logic               flush,
  input  logic               sys_ack,
  output logic               stall,
  output logic               ex_valid,
  output logic [9:0]         ex_ctrl,
  output logic [ALUOP_W-1:0] ex_ALUop,
  output logic [4:0]         ex_dst,
  output logic               sys_req,
  output logic               illegal
);

  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(7);

  localparam int C_REGDST = 9;
  localparam int C_JUMP   = 8;
  localparam int C_BRANCH = 7;
  localparam int C_MEMRD  = 6;
  localparam int C_MEM2R  = 5;
  localparam int C_REGWR  = 4;
  localparam int C_ALUSRC = 3;
  localparam int C_MEMWR  = 2;
  localparam int C_JR     = 1;
  localparam int C_JAL    = 0;

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SYS} state_t;

  state_t              state_q;
  logic [DW-1:0]       drain_q;
  logic                sys_req_q;

  logic                ex_valid_q, ex_valid_d;
  logic [9:0]          ex_ctrl_q, ex_ctrl_d;
  logic [ALUOP_W-1:0]  ex_alu_q, ex_alu_d;
  logic [4:0]          ex_dst_q, ex_dst_d;
  logic                illegal_q, illegal_d;

  logic [9:0]          dec_ctrl;
  logic [ALUOP_W-1:0]  dec_alu;
  logic [4:0]          dec_dst;
  logic                dec_ill, dec_sys, r_wr, i_wr;
  logic                reads_rt, load_use, md_stall, hazard, run, issue;

`ifdef PIPE_CTRL_MULDIV_EN
  logic                dec_md, dec_hilo;
  logic [7:0]          busy_q, busy_d;
`endif

  always_comb begin
    dec_ctrl = '0;
    dec_alu  = '0;
    dec_dst  = '0;
    dec_ill  = 1'b0;
    dec_sys  = 1'b0;
    r_wr     = 1'b0;
    i_wr     = 1'b0;
`ifdef PIPE_CTRL_MULDIV_EN
    dec_md   = 1'b0;
    dec_hilo = 1'b0;
`endif
    case (id_opcode)
      6'h00: begin
        case (id_func)
          6'h00: dec_ill = (id_rd != 5'd0);
          6'h08: dec_ctrl[C_JR] = 1'b1;
          6'h0C: dec_sys = 1'b1;
          6'h20, 6'h21: begin r_wr = 1'b1; dec_alu = ALU_ADD; end
          6'h22: begin r_wr = 1'b1; dec_alu = ALU_SUB; end
          6'h24: begin r_wr = 1'b1; dec_alu = ALU_AND; end
          6'h25: begin r_wr = 1'b1; dec_alu = ALU_OR;  end
          6'h26: begin r_wr = 1'b1; dec_alu = ALU_XOR; end
          6'h2A: begin r_wr = 1'b1; dec_alu = ALU_SLT; end
`ifdef PIPE_CTRL_MULDIV_EN
          6'h10, 6'h12: begin r_wr = 1'b1; dec_hilo = 1'b1; end
          6'h18, 6'h19, 6'h1A, 6'h1B: dec_md = 1'b1;
`endif
          default: dec_ill = 1'b1;
        endcase
      end
      6'h03: begin
        dec_ctrl[C_JUMP]  = 1'b1;
        dec_ctrl[C_JAL]   = 1'b1;
        dec_ctrl[C_REGWR] = 1'b1;
        dec_dst           = 5'd31;
      end
      6'h04, 6'h05: begin dec_ctrl[C_BRANCH] = 1'b1; dec_alu = ALU_SUB; end
      6'h08, 6'h09: begin i_wr = 1'b1; dec_alu = ALU_ADD; end
      6'h0A: begin i_wr = 1'b1; dec_alu = ALU_SLT; end
      6'h0C: begin i_wr = 1'b1; dec_alu = ALU_AND; end
      6'h0D: begin i_wr = 1'b1; dec_alu = ALU_OR;  end
      6'h0F: begin i_wr = 1'b1; dec_alu = ALU_LUI; end
      6'h23: begin
        i_wr               = 1'b1;
        dec_ctrl[C_MEMRD]  = 1'b1;
        dec_ctrl[C_MEM2R]  = 1'b1;
        dec_alu            = ALU_ADD;
      end
      6'h2B: begin
        dec_ctrl[C_MEMWR]  = 1'b1;
        dec_ctrl[C_ALUSRC] = 1'b1;
        dec_alu            = ALU_ADD;
      end
      default: dec_ill = 1'b1;
    endcase
    if (r_wr) begin
      dec_ctrl[C_REGDST] = 1'b1;
      dec_ctrl[C_REGWR]  = 1'b1;
      dec_dst            = id_rd;
    end
    if (i_wr) begin
      dec_ctrl[C_ALUSRC] = 1'b1;
      dec_ctrl[C_REGWR]  = 1'b1;
      dec_dst            = id_rt;
    end
  end

  // Only R-type, SW and the branches source rt; for the rest rt is a destination.
  assign reads_rt = (id_opcode == 6'h00) | (id_opcode == 6'h2B) |
                    (id_opcode == 6'h04) | (id_opcode == 6'h05);
  assign load_use = ex_valid_q & ex_ctrl_q[C_MEMRD] & (ex_dst_q != 5'd0) &
                    ((ex_dst_q == id_rs) | ((ex_dst_q == id_rt) & reads_rt));

`ifdef PIPE_CTRL_MULDIV_EN
  // busy_q > 1 means the unit is still occupied after this edge's decrement.
  assign md_stall = (dec_md | dec_hilo) & (busy_q > 8'd1);
`else
  assign md_stall = 1'b0;
`endif

  assign run    = (state_q == S_RUN);
  assign hazard = id_valid & (load_use | md_stall);
  assign stall  = ~run | (~flush & hazard);
  assign issue  = run & ~flush & ~hazard & id_valid;

  always_comb begin
    ex_valid_d = issue;
    ex_ctrl_d  = issue ? dec_ctrl : '0;
    ex_alu_d   = issue ? dec_alu  : '0;
    ex_dst_d   = issue ? dec_dst  : '0;
    illegal_d  = issue & dec_ill;
  end

`ifdef PIPE_CTRL_MULDIV_EN
  always_comb begin
    busy_d = busy_q;
    if (issue & dec_md)
      busy_d = 8'(MULDIV_LAT);
    else if (busy_q != 8'd0)
      busy_d = busy_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) busy_q <= 8'd0;
    else        busy_q <= busy_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_alu_q   <= '0;
      ex_dst_q   <= '0;
      illegal_q  <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_alu_q   <= ex_alu_d;
      ex_dst_q   <= ex_dst_d;
      illegal_q  <= illegal_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q   <= S_RUN;
      drain_q   <= '0;
      sys_req_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (issue & dec_sys) begin
            state_q <= S_DRAIN;
            drain_q <= DW'(DRAIN_CYCLES);
          end
        end
        S_DRAIN: begin
          if (drain_q <= DW'(1)) begin
            state_q   <= S_SYS;
            sys_req_q <= 1'b1;
          end else begin
            drain_q <= drain_q - DW'(1);
          end
        end
        S_SYS: begin
          if (sys_ack) begin
            state_q   <= S_RUN;
            sys_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_RUN;
          sys_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign ex_valid = ex_valid_q;
  assign ex_ctrl  = ex_ctrl_q;
  assign ex_ALUop = ex_alu_q;
  assign ex_dst   = ex_dst_q;
  assign sys_req  = sys_req_q;
  assign illegal  = illegal_q;

endmodule
